// File: rtl/reg_commit_sched.sv
// Commit scheduler: buffers up to two retired register writes per cycle and
// drains them in order onto a single commit port; on flush it drains, then clears r1..r31.
module reg_commit_sched #(
   parameter int ROB_W = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             in0_valid,
   input  logic [ROB_W-1:0] in0_rob_id,
   input  logic [4:0]       in0_rd,
   input  logic [31:0]      in0_value,
   input  logic             in1_valid,
   input  logic [ROB_W-1:0] in1_rob_id,
   input  logic [4:0]       in1_rd,
   input  logic [31:0]      in1_value,
   output logic             in_ready,
   output logic [ROB_W-1:0] commit_rob_id,
   output logic [4:0]       commit_rd,
   output logic [31:0]      commit_value,
   input  logic             flush_req,
   output logic             flush_clr,
   output logic [4:0]       flush_clr_rd,
   output logic             flush_done
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [4:0]       clr_idx;

   logic [ROB_W-1:0] fifo_id  [DEPTH];
   logic [4:0]       fifo_rd  [DEPTH];
   logic [31:0]      fifo_val [DEPTH];

   logic             push0;
   logic             push1;
   logic             pop;
   logic [1:0]       n_push;
   logic [PTR_W-1:0] wr_ptr1;

   // Readiness uses the registered count, so a same-cycle pop never adds room.
   assign in_ready = rdy && (state == S_RUN) && ((CNT_W'(DEPTH) - count) >= CNT_W'(2));

   // Writes to r0 are accepted but never stored.
   assign push0   = in_ready && in0_valid && (in0_rd != 5'd0);
   assign push1   = in_ready && in1_valid && (in1_rd != 5'd0);
   assign n_push  = {1'b0, push0} + {1'b0, push1};
   assign wr_ptr1 = wr_ptr + PTR_W'(push0);
   assign pop     = rdy && ((state == S_RUN) || (state == S_DRAIN)) && (count != '0);

   assign flush_clr    = (state == S_CLEAR);
   assign flush_clr_rd = flush_clr ? clr_idx : 5'd0;
   assign flush_done   = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (push0) begin
         fifo_id[wr_ptr]  <= in0_rob_id;
         fifo_rd[wr_ptr]  <= in0_rd;
         fifo_val[wr_ptr] <= in0_value;
      end
      if (push1) begin
         fifo_id[wr_ptr1]  <= in1_rob_id;
         fifo_rd[wr_ptr1]  <= in1_rd;
         fifo_val[wr_ptr1] <= in1_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_RUN;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         clr_idx       <= 5'd0;
         commit_rob_id <= '0;
         commit_rd     <= 5'd0;
         commit_value  <= 32'd0;
      end else if (rdy) begin
         if (pop) begin
            commit_rob_id <= fifo_id[rd_ptr];
            commit_rd     <= fifo_rd[rd_ptr];
            commit_value  <= fifo_val[rd_ptr];
            rd_ptr        <= rd_ptr + PTR_W'(1);
         end else begin
            commit_rob_id <= '0;
         end
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         count  <= count + CNT_W'(n_push) - CNT_W'(pop);

         case (state)
            S_RUN: begin
               if (flush_req) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (count == '0) begin
                  state   <= S_CLEAR;
                  clr_idx <= 5'd1;
               end
            end
            S_CLEAR: begin
               // Index wraps to 0 after r31, leaving it clean for the next flush.
               if (clr_idx == 5'd31) state <= S_DONE;
               clr_idx <= clr_idx + 5'd1;
            end
            default: begin
               state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_commit_sched.sv
// Bench for reg_commit_sched: queue-based reference model checked every cycle,
// plus directed ordering, rd0, backpressure, flush, stall and async-reset scenarios.
module tb_reg_commit_sched;

   localparam int ROB_W = 4;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst;
   logic             rdy;
   logic             in0_valid;
   logic [ROB_W-1:0] in0_rob_id;
   logic [4:0]       in0_rd;
   logic [31:0]      in0_value;
   logic             in1_valid;
   logic [ROB_W-1:0] in1_rob_id;
   logic [4:0]       in1_rd;
   logic [31:0]      in1_value;
   logic             in_ready;
   logic [ROB_W-1:0] commit_rob_id;
   logic [4:0]       commit_rd;
   logic [31:0]      commit_value;
   logic             flush_req;
   logic             flush_clr;
   logic [4:0]       flush_clr_rd;
   logic             flush_done;

   reg_commit_sched #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .in0_valid(in0_valid), .in0_rob_id(in0_rob_id), .in0_rd(in0_rd), .in0_value(in0_value),
      .in1_valid(in1_valid), .in1_rob_id(in1_rob_id), .in1_rd(in1_rd), .in1_value(in1_value),
      .in_ready(in_ready),
      .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
      .flush_req(flush_req), .flush_clr(flush_clr), .flush_clr_rd(flush_clr_rd),
      .flush_done(flush_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: a queue of pending writes and the flush phase.
   typedef struct {
      logic [ROB_W-1:0] id;
      logic [4:0]       rd;
      logic [31:0]      val;
   } ent_t;
   typedef enum int {M_RUN, M_DRAIN, M_CLEAR, M_DONE} mode_t;

   ent_t             q[$];
   mode_t            mode;
   int               clr;
   logic [ROB_W-1:0] exp_id;
   logic [4:0]       exp_rd;
   logic [31:0]      exp_val;

   function automatic bit model_ready();
      return rdy && (mode == M_RUN) && ((DEPTH - q.size()) >= 2);
   endfunction

   task automatic model_reset();
      q.delete();
      mode    = M_RUN;
      clr     = 0;
      exp_id  = '0;
      exp_rd  = '0;
      exp_val = '0;
   endtask

   task automatic model_step();
      int   n;
      bit   acc;
      ent_t e;
      if (!rdy) return;
      n   = q.size();
      acc = model_ready();
      if ((mode == M_RUN || mode == M_DRAIN) && n > 0) begin
         e       = q.pop_front();
         exp_id  = e.id;
         exp_rd  = e.rd;
         exp_val = e.val;
      end else begin
         exp_id = '0;
      end
      if (acc) begin
         if (in0_valid && in0_rd != 0) q.push_back('{in0_rob_id, in0_rd, in0_value});
         if (in1_valid && in1_rd != 0) q.push_back('{in1_rob_id, in1_rd, in1_value});
      end
      case (mode)
         M_RUN:   if (flush_req) mode = M_DRAIN;
         M_DRAIN: if (n == 0) begin mode = M_CLEAR; clr = 1; end
         M_CLEAR: if (clr == 31) mode = M_DONE; else clr++;
         default: mode = M_RUN;
      endcase
   endtask

   task automatic compare_outputs();
      check("in_ready", 64'(in_ready), 64'(model_ready()));
      check("commit_rob_id", 64'(commit_rob_id), 64'(exp_id));
      if (exp_id != 0) begin
         check("commit_rd", 64'(commit_rd), 64'(exp_rd));
         check("commit_value", 64'(commit_value), 64'(exp_val));
      end
      check("flush_clr", 64'(flush_clr), 64'(mode == M_CLEAR));
      check("flush_clr_rd", 64'(flush_clr_rd), 64'((mode == M_CLEAR) ? clr : 0));
      check("flush_done", 64'(flush_done), 64'(mode == M_DONE));
   endtask

   // Check the current cycle at the falling edge, advance the model, return just after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      compare_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      flush_req = 1'b0;
   endtask

   task automatic put(input bit slot, input int id, input int rd, input logic [31:0] v);
      if (!slot) begin
         in0_valid = 1'b1; in0_rob_id = ROB_W'(id); in0_rd = 5'(rd); in0_value = v;
      end else begin
         in1_valid = 1'b1; in1_rob_id = ROB_W'(id); in1_rd = 5'(rd); in1_value = v;
      end
   endtask

   task automatic async_rst(input string tag);
      #1;
      rst = 1'b1;
      #1;
      check({tag, "_commit_id"}, 64'(commit_rob_id), 64'(0));
      check({tag, "_commit_rd"}, 64'(commit_rd), 64'(0));
      check({tag, "_commit_val"}, 64'(commit_value), 64'(0));
      check({tag, "_clr"}, 64'(flush_clr), 64'(0));
      check({tag, "_clr_rd"}, 64'(flush_clr_rd), 64'(0));
      check({tag, "_done"}, 64'(flush_done), 64'(0));
      check({tag, "_ready"}, 64'(in_ready), 64'(1));
      rst = 1'b0;
      model_reset();
   endtask

   int nid;
   int got[$];
   bit acc;
   int ncommit, nclr, ndone, first_clr, last_commit, done_c, overlap, rdy_bad, seq_bad, n10;

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      in0_rob_id = '0; in0_rd = '0; in0_value = '0;
      in1_rob_id = '0; in1_rd = '0; in1_value = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_commit_id", 64'(commit_rob_id), 64'(0));
      check("reset_ready", 64'(in_ready), 64'(1));
      check("reset_clr", 64'(flush_clr), 64'(0));
      check("reset_done", 64'(flush_done), 64'(0));
      rst = 1'b0;
      cycle();

      // Ordering across two cycles.
      put(0, 1, 5, 32'hA); put(1, 2, 6, 32'hB);
      cycle();
      idle(); put(0, 3, 7, 32'hC);
      check("ord_c1", 64'(commit_rob_id), 64'(0));
      cycle();
      idle();
      check("ord_c2_id", 64'(commit_rob_id), 64'(1));
      check("ord_c2_rd", 64'(commit_rd), 64'(5));
      check("ord_c2_val", 64'(commit_value), 64'(32'hA));
      cycle();
      check("ord_c3_id", 64'(commit_rob_id), 64'(2));
      check("ord_c3_val", 64'(commit_value), 64'(32'hB));
      cycle();
      check("ord_c4_id", 64'(commit_rob_id), 64'(3));
      check("ord_c4_rd", 64'(commit_rd), 64'(7));
      cycle();
      check("ord_c5_id", 64'(commit_rob_id), 64'(0));
      cycle();

      // rd0 slot is dropped.
      put(0, 4, 0, 32'h44); put(1, 5, 3, 32'h55);
      cycle();
      idle();
      check("rd0_c1", 64'(commit_rob_id), 64'(0));
      cycle();
      check("rd0_c2_id", 64'(commit_rob_id), 64'(5));
      check("rd0_c2_rd", 64'(commit_rd), 64'(3));
      cycle();
      check("rd0_c3", 64'(commit_rob_id), 64'(0));
      cycle();

      // Backpressure: two requests every cycle, held while in_ready is low.
      nid = 1;
      for (int c = 0; c < 40; c++) begin
         idle();
         if (nid <= 12) begin
            put(0, nid, nid, 32'h100 + 32'(nid));
            put(1, nid + 1, nid + 1, 32'h100 + 32'(nid + 1));
         end
         if (c < 2) check("bp_ready_early", 64'(in_ready), 64'(1));
         if (c == 2) check("bp_ready_c2", 64'(in_ready), 64'(0));
         if (commit_rob_id != 0) got.push_back(int'(commit_rob_id));
         acc = in_ready && (nid <= 12);
         cycle();
         if (acc) nid += 2;
      end
      idle();
      check("bp_count", 64'(got.size()), 64'(12));
      foreach (got[i]) check("bp_order", 64'(got[i]), 64'(i + 1));

      // Flush with three pending entries; a second request during CLEAR is ignored.
      put(0, 6, 1, 32'h6); put(1, 7, 2, 32'h7);
      cycle();
      idle(); put(0, 8, 3, 32'h8); flush_req = 1'b1;
      cycle();
      idle();
      ncommit = 0; nclr = 0; ndone = 0; first_clr = -1; last_commit = -1;
      done_c = -1; overlap = 0; rdy_bad = 0; seq_bad = 0;
      for (int c = 2; c < 45; c++) begin
         flush_req = (c == 10);
         if (commit_rob_id != 0) begin ncommit++; last_commit = c; end
         if (flush_clr) begin
            nclr++;
            if (first_clr < 0) first_clr = c;
            if (flush_clr_rd != 5'(nclr)) seq_bad++;
         end
         if (flush_done) begin ndone++; done_c = c; end
         if (flush_clr && commit_rob_id != 0) overlap++;
         if (c < 37 && in_ready) rdy_bad++;
         cycle();
      end
      idle();
      check("fl_commits", 64'(ncommit), 64'(3));
      check("fl_last_commit", 64'(last_commit), 64'(4));
      check("fl_first_clr", 64'(first_clr), 64'(5));
      check("fl_nclr", 64'(nclr), 64'(31));
      check("fl_clr_seq", 64'(seq_bad), 64'(0));
      check("fl_ndone", 64'(ndone), 64'(1));
      check("fl_done_cycle", 64'(done_c), 64'(36));
      check("fl_overlap", 64'(overlap), 64'(0));
      check("fl_ready_low", 64'(rdy_bad), 64'(0));

      // Stall during CLEAR at rd 10: done moves from cycle 33 to 36.
      done_c = -1; n10 = 0;
      for (int c = 0; c < 45; c++) begin
         rdy = !(c >= 11 && c <= 13);
         flush_req = (c == 0);
         if (flush_clr && flush_clr_rd == 5'd10) n10++;
         if (flush_done && done_c < 0) done_c = c;
         cycle();
      end
      rdy = 1'b1;
      idle();
      check("stall_rd10_cycles", 64'(n10), 64'(4));
      check("stall_done_cycle", 64'(done_c), 64'(36));

      // Randomized traffic with stalls and occasional flushes.
      nid = 1;
      for (int c = 0; c < 800; c++) begin
         rdy       = ($urandom_range(0, 9) != 0);
         flush_req = ($urandom_range(0, 49) == 0);
         in0_valid = $urandom_range(0, 1);
         in0_rob_id = ROB_W'(nid); nid = (nid % 15) + 1;
         in0_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         in0_value = $urandom;
         in1_valid = $urandom_range(0, 1);
         in1_rob_id = ROB_W'(nid); nid = (nid % 15) + 1;
         in1_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         in1_value = $urandom;
         cycle();
      end
      rdy = 1'b1;
      idle();

      // Asynchronous reset from arbitrary state, with a commit showing, and during CLEAR.
      async_rst("arst_rand");
      cycle();
      put(0, 9, 4, 32'h99); put(1, 10, 5, 32'hAA);
      cycle();
      idle();
      cycle();
      check("arst_pre_commit", 64'(commit_rob_id), 64'(9));
      async_rst("arst_commit");
      cycle();
      put(0, 11, 6, 32'hBB);
      cycle();
      idle(); flush_req = 1'b1;
      cycle();
      idle();
      repeat (6) cycle();
      check("arst_pre_clr", 64'(flush_clr), 64'(1));
      async_rst("arst_clear");
      repeat (3) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
